// File: rtl/rram_pkg.sv
// Shared types, field offsets and packing helpers for the RRAM readout capture block.
package rram_pkg;

    localparam int ARRAY_SIZE = 16;
    localparam int WB_DATA_W  = 32;
    localparam int CODE_W     = 3;
    localparam int SUM_LSB    = 18;
    localparam int SUM_W      = 7;
    localparam int CNT_W      = 4;
    localparam int CODES_W    = ARRAY_SIZE * CODE_W;
    localparam int W0_CODES   = 10;

    localparam logic MODE_CSA = 1'b0;
    localparam logic MODE_ADC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_PUSH0  = 3'd3,
        ST_PUSH1  = 3'd4
    } state_e;

    // Column i's 3-bit code lands at bits [3i+2:3i].
    function automatic logic [CODES_W-1:0] pack_codes(
        input logic [ARRAY_SIZE-1:0] b0,
        input logic [ARRAY_SIZE-1:0] b1,
        input logic [ARRAY_SIZE-1:0] b2
    );
        logic [CODES_W-1:0] codes;
        codes = {CODES_W{1'b0}};
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            codes[i*CODE_W +: CODE_W] = {b2[i], b1[i], b0[i]};
        end
        return codes;
    endfunction

    function automatic logic [SUM_W-1:0] sum_codes(input logic [CODES_W-1:0] codes);
        logic [SUM_W-1:0] s;
        s = {SUM_W{1'b0}};
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            s = s + SUM_W'(codes[i*CODE_W +: CODE_W]);
        end
        return s;
    endfunction

endpackage

// File: rtl/rram_readout_capture_if.sv
// Capture request, sense inputs and result-FIFO read port of the readout capture block.
interface rram_readout_capture_if;
    import rram_pkg::*;

    logic                  capture_req;
    logic                  mode;
    logic [ARRAY_SIZE-1:0] CSA;
    logic [ARRAY_SIZE-1:0] ADC_OUT0;
    logic [ARRAY_SIZE-1:0] ADC_OUT1;
    logic [ARRAY_SIZE-1:0] ADC_OUT2;
    logic                  busy;
    logic                  rd_en;
    logic [WB_DATA_W-1:0]  rd_data;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CNT_W-1:0]      fifo_count;
    logic                  clr_err;
    logic                  overflow;
    logic                  req_lost;

    modport master (
        output capture_req, mode, CSA, ADC_OUT0, ADC_OUT1, ADC_OUT2, rd_en, clr_err,
        input  busy, rd_data, fifo_empty, fifo_full, fifo_count, overflow, req_lost
    );

    modport slave (
        input  capture_req, mode, CSA, ADC_OUT0, ADC_OUT1, ADC_OUT2, rd_en, clr_err,
        output busy, rd_data, fifo_empty, fifo_full, fifo_count, overflow, req_lost
    );

endinterface

// File: rtl/rram_result_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; a push into a full FIFO without
// a simultaneous pop is dropped and reported as a one-cycle overflow pulse.
module rram_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             ovf_pulse
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s, full_s, empty_s;

    // Pointer, count and storage updates; a pop on a full FIFO frees the slot for a same-cycle push.
    always_comb begin
        empty_s   = (count_q == CNT_W'(0));
        full_s    = (count_q == CNT_W'(DEPTH));
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
        ovf_pulse = push && full_s && !pop;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written since the head is gated by empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
    assign empty = empty_s;
    assign full  = full_s;
    assign count = count_q;

endmodule

// File: rtl/rram_readout_capture.sv
// Samples CSA or ADC bit-planes after a settle delay, packs them into 32-bit words
// and queues them in the result FIFO; sticky flags report dropped words and lost requests.
module rram_readout_capture
    import rram_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    rram_readout_capture_if.slave  bus
);
    localparam int         FCNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e                state_q, state_d;
    logic [3:0]            settle_q, settle_d;
    logic                  mode_q, mode_d;
    logic [ARRAY_SIZE-1:0] csa_q, csa_d;
    logic [ARRAY_SIZE-1:0] adc0_q, adc0_d;
    logic [ARRAY_SIZE-1:0] adc1_q, adc1_d;
    logic [ARRAY_SIZE-1:0] adc2_q, adc2_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;
    logic                  req_lost_q, req_lost_d;

    logic                  push_s;
    logic [WB_DATA_W-1:0]  push_data_s;
    logic [CODES_W-1:0]    codes_s;
    logic [SUM_W-1:0]      sum_s;
    logic                  ovf_pulse_s;
    logic [FCNT_W-1:0]     fifo_count_s;

    // State register and all datapath/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            settle_q   <= 4'd0;
            mode_q     <= MODE_CSA;
            csa_q      <= '0;
            adc0_q     <= '0;
            adc1_q     <= '0;
            adc2_q     <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            req_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            mode_q     <= mode_d;
            csa_q      <= csa_d;
            adc0_q     <= adc0_d;
            adc1_q     <= adc1_d;
            adc2_q     <= adc2_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            req_lost_q <= req_lost_d;
        end
    end

    // Next-state logic, settle countdown and mode latch.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        mode_d   = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.capture_req) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LOAD;
                    mode_d   = bus.mode;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_SAMPLE: state_d = ST_PUSH0;
            ST_PUSH0:  state_d = (mode_q == MODE_ADC) ? ST_PUSH1 : ST_IDLE;
            ST_PUSH1:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sample registers, busy and sticky flags; a set event beats a coincident clear.
    always_comb begin
        if (state_q == ST_SAMPLE) begin
            csa_d  = bus.CSA;
            adc0_d = bus.ADC_OUT0;
            adc1_d = bus.ADC_OUT1;
            adc2_d = bus.ADC_OUT2;
        end else begin
            csa_d  = csa_q;
            adc0_d = adc0_q;
            adc1_d = adc1_q;
            adc2_d = adc2_q;
        end
        busy_d = (state_d != ST_IDLE);
        if (bus.capture_req && (state_q != ST_IDLE)) begin
            req_lost_d = 1'b1;
        end else if (bus.clr_err) begin
            req_lost_d = 1'b0;
        end else begin
            req_lost_d = req_lost_q;
        end
        if (ovf_pulse_s) begin
            overflow_d = 1'b1;
        end else if (bus.clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Output logic: word selection and FIFO push strobe.
    always_comb begin
        codes_s     = pack_codes(adc0_q, adc1_q, adc2_q);
        sum_s       = sum_codes(codes_s);
        push_s      = 1'b0;
        push_data_s = {WB_DATA_W{1'b0}};
        case (state_q)
            ST_PUSH0: begin
                push_s = 1'b1;
                if (mode_q == MODE_ADC) begin
                    push_data_s = WB_DATA_W'(codes_s[W0_CODES*CODE_W-1:0]);
                end else begin
                    push_data_s = WB_DATA_W'(csa_q);
                end
            end
            ST_PUSH1: begin
                push_s      = 1'b1;
                push_data_s = (WB_DATA_W'(sum_s) << SUM_LSB)
                            | WB_DATA_W'(codes_s[CODES_W-1 -: SUM_LSB]);
            end
            default: begin
                push_s      = 1'b0;
                push_data_s = {WB_DATA_W{1'b0}};
            end
        endcase
    end

    rram_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WB_DATA_W),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (bus.rd_en),
        .head      (bus.rd_data),
        .empty     (bus.fifo_empty),
        .full      (bus.fifo_full),
        .count     (fifo_count_s),
        .ovf_pulse (ovf_pulse_s)
    );

    assign bus.fifo_count = CNT_W'(fifo_count_s);
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.req_lost   = req_lost_q;

endmodule

// File: tb/tb_rram_readout_capture.sv
// Self-checking bench: table-driven captures with a word scoreboard plus hand-written corner sequences.
module tb_rram_readout_capture;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] sb [$];

    rram_readout_capture_if bus ();

    rram_readout_capture #(
        .FIFO_DEPTH    (8),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [15:0] csa;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic m, input logic [15:0] c, input logic [15:0] a0,
                              input logic [15:0] a1, input logic [15:0] a2);
        bus.mode     = m;
        bus.CSA      = c;
        bus.ADC_OUT0 = a0;
        bus.ADC_OUT1 = a1;
        bus.ADC_OUT2 = a2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic capture(input logic m, input logic [15:0] c, input logic [15:0] a0,
                           input logic [15:0] a1, input logic [15:0] a2);
        set_inputs(m, c, a0, a1, a2);
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        wait_idle();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!bus.fifo_empty && n < 20) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_extra actual=%h required=no_word", name, bus.rd_data);
            end else begin
                check(name, bus.rd_data, sb.pop_front());
            end
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
            n++;
        end
        check({name, "_empty"}, {31'd0, bus.fifo_empty}, 32'd1);
        check({name, "_missing"}, sb.size(), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.capture_req = 1'b0;
        bus.rd_en       = 1'b0;
        bus.clr_err     = 1'b0;
        set_inputs(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        vecs[0] = '{1'b0, 16'hA5C3, 16'h0000, 16'h0000, 16'h0000, 32'h0000A5C3, 32'h0};
        vecs[1] = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 32'h2DB6DB6D, 32'h0142DB6D};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 32'h00000000, 32'h00000000};
        vecs[3] = '{1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h3FFFFFFF, 32'h01C3FFFF};
        vecs[4] = '{1'b1, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 32'h00000001, 32'h00040000};
        vecs[5] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 32'h00000000, 32'h00120000};
        vecs[6] = '{1'b1, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 32'h00000000, 32'h00080002};
        vecs[7] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h5678, 32'h0000FFFF, 32'h0};
        vecs[8] = '{1'b1, 16'h0000, 16'h0200, 16'h0200, 16'h0000, 32'h18000000, 32'h000C0000};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy",     {31'd0, bus.busy},       32'd0);
        check("rst_empty",    {31'd0, bus.fifo_empty}, 32'd1);
        check("rst_full",     {31'd0, bus.fifo_full},  32'd0);
        check("rst_rd_data",  bus.rd_data,             32'd0);
        check("rst_count",    {28'd0, bus.fifo_count}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow},   32'd0);
        check("rst_req_lost", {31'd0, bus.req_lost},   32'd0);

        // Cycle-accurate CSA capture: busy in cycles 1..4, word visible in cycle 5.
        set_inputs(1'b0, 16'hA5C3, 16'h0000, 16'h0000, 16'h0000);
        sb.push_back(32'h0000A5C3);
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("busy_c%0d", c),  {31'd0, bus.busy},       {31'd0, (c <= 4)});
            check($sformatf("empty_c%0d", c), {31'd0, bus.fifo_empty}, {31'd0, (c <= 4)});
            if (c < 5) tick();
        end
        check("csa_count", {28'd0, bus.fifo_count}, 32'd1);
        drain("csa_word");

        for (int i = 0; i < 9; i++) begin
            sb.push_back(vecs[i].w0);
            if (vecs[i].mode) sb.push_back(vecs[i].w1);
            capture(vecs[i].mode, vecs[i].csa, vecs[i].a0, vecs[i].a1, vecs[i].a2);
            check($sformatf("vec%0d_count", i), {28'd0, bus.fifo_count},
                  vecs[i].mode ? 32'd2 : 32'd1);
            drain($sformatf("vec%0d_word", i));
        end

        // Fill the FIFO, then a 9th capture is dropped.
        for (int i = 0; i < 8; i++) begin
            sb.push_back(32'h00001000 + i);
            capture(1'b0, 16'h1000 + 16'(i), 16'h0, 16'h0, 16'h0);
        end
        check("fill_full",  {31'd0, bus.fifo_full},  32'd1);
        check("fill_count", {28'd0, bus.fifo_count}, 32'd8);
        check("fill_ovf",   {31'd0, bus.overflow},   32'd0);
        capture(1'b0, 16'hDEAD, 16'h0, 16'h0, 16'h0);
        check("ovf_set",   {31'd0, bus.overflow},   32'd1);
        check("ovf_count", {28'd0, bus.fifo_count}, 32'd8);
        check("ovf_head",  bus.rd_data,             sb[0]);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("ovf_clr", {31'd0, bus.overflow}, 32'd0);

        // Pop in the PUSH0 cycle of a capture while full: both succeed.
        set_inputs(1'b0, 16'hBEEF, 16'h0, 16'h0, 16'h0);
        sb.push_back(32'h0000BEEF);
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        tick();
        tick();
        tick();
        check("pp_head", bus.rd_data, sb.pop_front());
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("pp_ovf",   {31'd0, bus.overflow},   32'd0);
        check("pp_count", {28'd0, bus.fifo_count}, 32'd8);
        check("pp_busy",  {31'd0, bus.busy},       32'd0);
        drain("pp_word");

        // Second request two cycles into a capture is lost.
        set_inputs(1'b0, 16'h1111, 16'h0, 16'h0, 16'h0);
        sb.push_back(32'h00001111);
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        tick();
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        check("lost_set", {31'd0, bus.req_lost}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check("lost_busy",  {31'd0, bus.busy},       32'd0);
        check("lost_count", {28'd0, bus.fifo_count}, 32'd1);
        drain("lost_word");

        // Request in the PUSH0 cycle (return to IDLE) is also lost.
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("lost_clr", {31'd0, bus.req_lost}, 32'd0);
        set_inputs(1'b0, 16'h2222, 16'h0, 16'h0, 16'h0);
        sb.push_back(32'h00002222);
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        tick();
        tick();
        tick();
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        check("edge_lost", {31'd0, bus.req_lost}, 32'd1);
        check("edge_busy", {31'd0, bus.busy},     32'd0);
        for (int i = 0; i < 8; i++) tick();
        drain("edge_word");

        // Set event coinciding with clr_err: set wins.
        set_inputs(1'b0, 16'h3333, 16'h0, 16'h0, 16'h0);
        sb.push_back(32'h00003333);
        bus.capture_req = 1'b1;
        tick();
        bus.clr_err = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        bus.clr_err     = 1'b0;
        check("setwins_lost", {31'd0, bus.req_lost}, 32'd1);
        wait_idle();
        drain("setwins_word");

        // Reset during SETTLE aborts the capture.
        set_inputs(1'b0, 16'h4444, 16'h0, 16'h0, 16'h0);
        bus.capture_req = 1'b1;
        tick();
        bus.capture_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",  {31'd0, bus.busy},       32'd0);
        check("abort_empty", {31'd0, bus.fifo_empty}, 32'd1);
        check("abort_lost",  {31'd0, bus.req_lost},   32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("abort_empty_late", {31'd0, bus.fifo_empty}, 32'd1);
        check("abort_count",      {28'd0, bus.fifo_count}, 32'd0);
        drain("abort_word");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
